// File: rtl/uart_host_pkg.sv
// Shared constants, state encoding and CRC-8 step function for the
// UART-AXI bridge host-side command master.
package uart_host_pkg;

  localparam logic [7:0] SOF_H2D   = 8'hA5;
  localparam logic [7:0] SOF_D2H   = 8'h5A;
  localparam logic [7:0] CMD_WRITE = 8'h20;
  localparam logic [7:0] CMD_READ  = 8'h10;
  localparam logic [7:0] CRC_POLY  = 8'h07;

  localparam int ERR_CRC     = 0;
  localparam int ERR_ECHO    = 1;
  localparam int ERR_TIMEOUT = 2;

  // Full frame lengths including SOF and CRC.
  localparam logic [3:0] TX_LEN_WR = 4'd11;
  localparam logic [3:0] TX_LEN_RD = 4'd7;
  localparam logic [3:0] RX_LEN_WR = 4'd4;
  localparam logic [3:0] RX_LEN_RD = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX      = 3'd1,
    ST_RX_SOF  = 3'd2,
    ST_RX_BODY = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_host_cmd_master_crc8.sv
// Byte-serial CRC-8 accumulator; one byte per cycle, registered result.
module uart_crc8
  import uart_host_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  // Clear wins over update so a new frame never inherits stale state.
  always_comb begin
    if (clear) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = crc8_update(crc_q, data);
    end else begin
      crc_d = crc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/uart_host_cmd_master.sv
// Host-side UART-AXI bridge initiator: serializes one read/write command
// frame, then parses and checks the device response.
module uart_host_cmd_master
  import uart_host_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [7:0]  rsp_status,
  output logic [31:0] rsp_rdata,
  output logic [3:0]  rsp_err,
  output logic        busy
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e state_q, state_d;

  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       status_q, status_d;
  logic [7:0]       echo_q, echo_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rsp_status_q, rsp_status_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic [3:0]       rsp_err_q, rsp_err_d;

  logic       crc_clear;
  logic       crc_en;
  logic [7:0] crc_data;
  logic [7:0] crc_val;
  logic [7:0] tx_byte;
  logic [7:0] cmd_byte;
  logic [3:0] tx_last;
  logic [3:0] rx_last;
  logic       timeout_hit;
  logic       crc_bad;
  logic       echo_bad;

  uart_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (crc_clear),
    .en    (crc_en),
    .data  (crc_data),
    .crc   (crc_val)
  );

  assign cmd_byte    = write_q ? CMD_WRITE : CMD_READ;
  assign tx_last     = write_q ? (TX_LEN_WR - 4'd1) : (TX_LEN_RD - 4'd1);
  // RX index counts from the byte after SOF, so the CRC sits at length-2.
  assign rx_last     = write_q ? (RX_LEN_WR - 4'd2) : (RX_LEN_RD - 4'd2);
  assign timeout_hit = (cnt_q == CNT_LAST) && !rx_valid;
  assign crc_bad     = (rx_data != crc_val);
  assign echo_bad    = (echo_q != cmd_byte);

  // Command frame byte selected by the TX index.
  always_comb begin
    tx_byte = 8'h00;
    case (idx_q)
      4'd0:    tx_byte = SOF_H2D;
      4'd1:    tx_byte = cmd_byte;
      4'd2:    tx_byte = addr_q[7:0];
      4'd3:    tx_byte = addr_q[15:8];
      4'd4:    tx_byte = addr_q[23:16];
      4'd5:    tx_byte = addr_q[31:24];
      4'd6:    tx_byte = write_q ? wdata_q[7:0] : crc_val;
      4'd7:    tx_byte = wdata_q[15:8];
      4'd8:    tx_byte = wdata_q[23:16];
      4'd9:    tx_byte = wdata_q[31:24];
      4'd10:   tx_byte = crc_val;
      default: tx_byte = 8'h00;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = ST_TX;
        else           state_d = ST_IDLE;
      end
      ST_TX: begin
        if (tx_ready && (idx_q == tx_last)) state_d = ST_RX_SOF;
        else                                state_d = ST_TX;
      end
      ST_RX_SOF: begin
        if (rx_valid && (rx_data == SOF_D2H)) state_d = ST_RX_BODY;
        else if (timeout_hit)                 state_d = ST_DONE;
        else                                  state_d = ST_RX_SOF;
      end
      ST_RX_BODY: begin
        if (rx_valid && (idx_q == rx_last)) state_d = ST_DONE;
        else if (timeout_hit)               state_d = ST_DONE;
        else                                state_d = ST_RX_BODY;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: request latch, byte index, response capture, CRC control, timeout.
  always_comb begin
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    status_d     = status_q;
    echo_d       = echo_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    rsp_status_d = rsp_status_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    crc_clear    = 1'b0;
    crc_en       = 1'b0;
    crc_data     = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d   = req_write;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          idx_d     = 4'd0;
          crc_clear = 1'b1;
        end else begin
          idx_d = 4'd0;
        end
      end
      ST_TX: begin
        cnt_d = '0;
        if (tx_ready) begin
          idx_d = (idx_q == tx_last) ? 4'd0 : (idx_q + 4'd1);
          if ((idx_q != 4'd0) && (idx_q != tx_last)) begin
            crc_en   = 1'b1;
            crc_data = tx_byte;
          end else begin
            crc_en = 1'b0;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_RX_SOF, ST_RX_BODY: begin
        if (rx_valid) begin
          cnt_d = '0;
          if (state_q == ST_RX_SOF) begin
            if (rx_data == SOF_D2H) begin
              crc_clear = 1'b1;
              idx_d     = 4'd0;
            end else begin
              idx_d = idx_q;
            end
          end else begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd0)      status_d = rx_data;
            else if (idx_q == 4'd1) echo_d   = rx_data;
            else                    rdata_d  = {rx_data, rdata_q[31:8]};
            if (idx_q != rx_last) begin
              crc_en   = 1'b1;
              crc_data = rx_data;
            end else begin
              rsp_err_d              = 4'b0000;
              rsp_err_d[ERR_CRC]     = crc_bad;
              rsp_err_d[ERR_ECHO]    = echo_bad;
              if (crc_bad || echo_bad) begin
                rsp_status_d = 8'h00;
                rsp_rdata_d  = 32'h0000_0000;
              end else begin
                rsp_status_d = status_q;
                rsp_rdata_d  = (write_q || (status_q != 8'h00)) ? 32'h0000_0000 : rdata_q;
              end
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (timeout_hit) begin
            rsp_status_d           = 8'h00;
            rsp_rdata_d            = 32'h0000_0000;
            rsp_err_d              = 4'b0000;
            rsp_err_d[ERR_TIMEOUT] = 1'b1;
          end else begin
            rsp_err_d = rsp_err_q;
          end
        end
      end
      ST_DONE: begin
        idx_d = 4'd0;
      end
      default: begin
        idx_d = 4'd0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_q      <= 1'b0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      idx_q        <= 4'd0;
      status_q     <= 8'h00;
      echo_q       <= 8'h00;
      rdata_q      <= 32'h0000_0000;
      cnt_q        <= '0;
      rsp_status_q <= 8'h00;
      rsp_rdata_q  <= 32'h0000_0000;
      rsp_err_q    <= 4'b0000;
    end else begin
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      idx_q        <= idx_d;
      status_q     <= status_d;
      echo_q       <= echo_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      rsp_status_q <= rsp_status_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Outputs decoded from state; forced low whenever reset is held.
  always_comb begin
    req_ready  = 1'b0;
    busy       = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    rsp_valid  = 1'b0;
    rsp_status = 8'h00;
    rsp_rdata  = 32'h0000_0000;
    rsp_err    = 4'b0000;
    if (rst_n) begin
      req_ready = (state_q == ST_IDLE);
      busy      = (state_q != ST_IDLE);
      tx_valid  = (state_q == ST_TX);
      tx_data   = (state_q == ST_TX) ? tx_byte : 8'h00;
      if (state_q == ST_DONE) begin
        rsp_valid  = 1'b1;
        rsp_status = rsp_status_q;
        rsp_rdata  = rsp_rdata_q;
        rsp_err    = rsp_err_q;
      end else begin
        rsp_valid = 1'b0;
      end
    end else begin
      req_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_host_cmd_master.sv
// Directed self-checking bench for uart_host_cmd_master with a frame-level
// reference model and a per-cycle compare process.
module tb_uart_host_cmd_master;

  localparam int unsigned TO = 100;
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        req_ready, tx_valid, rsp_valid, busy;
  logic [7:0]  tx_data, rsp_status;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic stall_mode = 1'b0;

  bq_t         exp_tx;
  logic        exp_pending = 1'b0;
  int          exp_cyc = 0;
  logic [7:0]  exp_st = 8'h00;
  logic [31:0] exp_rd = 32'h0;
  logic [3:0]  exp_err = 4'h0;
  int          last_hs_cyc = 0;
  int          rsp_seen = 0;

  uart_host_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CRC-8 poly 0x07 as bitwise long division, MSB first.
  function automatic logic [7:0] crc8(input bq_t b);
    logic [7:0] c = 8'h00;
    logic fb;
    foreach (b[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ b[i][k];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  function automatic bq_t cmd_frame(input logic w, input logic [31:0] a, input logic [31:0] d);
    bq_t body;
    bq_t f;
    body.push_back(w ? 8'h20 : 8'h10);
    for (int i = 0; i < 4; i++) body.push_back(a[8*i +: 8]);
    if (w) for (int i = 0; i < 4; i++) body.push_back(d[8*i +: 8]);
    f.push_back(8'hA5);
    foreach (body[i]) f.push_back(body[i]);
    f.push_back(crc8(body));
    return f;
  endfunction

  function automatic bq_t make_rsp(input logic w, input logic [7:0] st, input logic [7:0] echo,
                                   input logic [31:0] d, input logic [7:0] crc_flip);
    bq_t body;
    bq_t r;
    body.push_back(st);
    body.push_back(echo);
    if (!w) for (int i = 0; i < 4; i++) body.push_back(d[8*i +: 8]);
    r.push_back(8'h5A);
    foreach (body[i]) r.push_back(body[i]);
    r.push_back(crc8(body) ^ crc_flip);
    return r;
  endfunction

  // Expected completion derived from the response bytes and the request type.
  task automatic set_expect(input bq_t r, input logic w);
    bq_t body;
    bq_t covered;
    int s = -1;
    logic crc_ok, echo_ok;
    foreach (r[i]) if (s < 0 && r[i] == 8'h5A) s = i;
    for (int i = s + 1; i < r.size(); i++) body.push_back(r[i]);
    for (int i = 0; i < body.size() - 1; i++) covered.push_back(body[i]);
    crc_ok  = (crc8(covered) == body[body.size()-1]);
    echo_ok = (body[1] == (w ? 8'h20 : 8'h10));
    exp_err = {2'b00, !echo_ok, !crc_ok};
    if (exp_err != 4'h0) begin
      exp_st = 8'h00;
      exp_rd = 32'h0;
    end else begin
      exp_st = body[0];
      exp_rd = (!w && body[0] == 8'h00) ? {body[5], body[4], body[3], body[2]} : 32'h0;
    end
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("req_ready_before_req", req_ready, 1'b1);
    exp_tx = cmd_frame(w, a, d);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    chk("tx_valid_1cyc_after_accept", tx_valid, 1'b1);
  endtask

  task automatic wait_tx();
    int n = 0;
    while (exp_tx.size() != 0 && n < 300) begin tick(); n++; end
    chk("tx_frame_complete_remaining", exp_tx.size(), 0);
  endtask

  task automatic send_rsp(input bq_t r, input logic w);
    int seen0 = rsp_seen;
    set_expect(r, w);
    foreach (r[i]) begin
      rx_data  = r[i];
      rx_valid = 1'b1;
      if (i == r.size() - 1) begin
        exp_cyc     = cyc + 1;
        exp_pending = 1'b1;
      end
      tick();
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();
    chk("rsp_count", rsp_seen, seen0 + 1);
  endtask

  // Compare process: TX stream, stall stability, response timing and content.
  initial begin
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic chk_ready_next = 1'b0;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        chk_ready_next = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("tx_hold_valid", tx_valid, 1'b1);
          chk("tx_hold_data", tx_data, prev_data);
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (tx_valid && tx_ready) begin
          checks++;
          if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_extra_byte: got %0h expected no byte (cycle %0d)", tx_data, cyc);
          end else begin
            b = exp_tx.pop_front();
            if (tx_data !== b) begin
              errors++;
              $display("FAIL tx_byte: got %0h expected %0h (cycle %0d)", tx_data, b, cyc);
            end
            if (exp_tx.size() == 0) last_hs_cyc = cyc;
          end
        end
        if (chk_ready_next) begin
          chk("req_ready_after_rsp", req_ready, 1'b1);
          chk_ready_next = 1'b0;
        end
        if (rsp_valid || (exp_pending && cyc == exp_cyc)) begin
          chk("rsp_valid_timing", rsp_valid, exp_pending && (cyc == exp_cyc));
          if (rsp_valid && exp_pending && cyc == exp_cyc) begin
            chk("rsp_status", rsp_status, exp_st);
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("rsp_err", rsp_err, exp_err);
            chk("req_ready_in_done", req_ready, 1'b0);
            chk_ready_next = 1'b1;
          end
          if (exp_pending && cyc == exp_cyc) begin
            exp_pending = 1'b0;
            rsp_seen++;
          end
        end
        chk("busy_vs_ready", busy, !req_ready);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f;
    bq_t q;
    logic [7:0] lit_w[10] = '{8'hA5, 8'h20, 8'h20, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] lit_r[6]  = '{8'hA5, 8'h10, 8'h20, 8'h10, 8'h00, 8'h00};

    // Reset state.
    repeat (3) tick();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_rsp_fields", {rsp_status, rsp_err}, 12'h000);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("req_ready_after_reset", req_ready, 1'b1);

    // Pin the reference model against known values.
    q = {};
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    chk("model_crc_check_string", crc8(q), 8'hF4);
    q = {};
    q.push_back(8'h01);
    chk("model_crc_01", crc8(q), 8'h07);
    f = cmd_frame(1'b1, 32'h0000_1020, 32'hDEAD_BEEF);
    chk("model_wr_len", f.size(), 11);
    for (int i = 0; i < 10; i++) chk("model_wr_byte", f[i], lit_w[i]);
    f = cmd_frame(1'b0, 32'h0000_1020, 32'h0);
    chk("model_rd_len", f.size(), 7);
    for (int i = 0; i < 6; i++) chk("model_rd_byte", f[i], lit_r[i]);
    set_expect(make_rsp(1'b0, 8'h00, 8'h10, 32'hCAFE_BABE, 8'h00), 1'b0);
    chk("model_rd_data", exp_rd, 32'hCAFE_BABE);

    // Write then read, no stalls.
    do_req(1'b1, 32'h0000_1020, 32'hDEAD_BEEF); wait_tx();
    send_rsp(make_rsp(1'b1, 8'h00, 8'h20, 32'h0, 8'h00), 1'b1);
    do_req(1'b0, 32'h0000_1020, 32'h0); wait_tx();
    send_rsp(make_rsp(1'b0, 8'h00, 8'h10, 32'hCAFE_BABE, 8'h00), 1'b0);

    // Same transactions with random TX stalls.
    stall_mode = 1'b1;
    do_req(1'b1, 32'h0000_1020, 32'hDEAD_BEEF); wait_tx();
    send_rsp(make_rsp(1'b1, 8'h00, 8'h20, 32'h0, 8'h00), 1'b1);
    do_req(1'b0, 32'h8000_0004, 32'h0); wait_tx();
    send_rsp(make_rsp(1'b0, 8'h00, 8'h10, 32'h0102_0304, 8'h00), 1'b0);
    stall_mode = 1'b0;

    // Corrupted CRC on read.
    do_req(1'b0, 32'h0000_1020, 32'h0); wait_tx();
    send_rsp(make_rsp(1'b0, 8'h00, 8'h10, 32'hCAFE_BABE, 8'h01), 1'b0);
    chk("model_crc_err", exp_err, 4'b0001);

    // Wrong echo on write.
    do_req(1'b1, 32'h0000_2000, 32'h1234_5678); wait_tx();
    send_rsp(make_rsp(1'b1, 8'h00, 8'h10, 32'h0, 8'h00), 1'b1);
    chk("model_echo_err", exp_err, 4'b0010);

    // Garbage before SOF.
    do_req(1'b0, 32'h0000_3000, 32'h0); wait_tx();
    q = {};
    q.push_back(8'hFF);
    q.push_back(8'h00);
    f = make_rsp(1'b0, 8'h00, 8'h10, 32'h1234_5678, 8'h00);
    foreach (f[i]) q.push_back(f[i]);
    send_rsp(q, 1'b0);

    // Nonzero device status.
    do_req(1'b0, 32'h0000_4000, 32'h0); wait_tx();
    send_rsp(make_rsp(1'b0, 8'h03, 8'h10, 32'hAAAA_5555, 8'h00), 1'b0);
    chk("model_status_pass", exp_st, 8'h03);

    // Timeout with no response.
    do_req(1'b1, 32'h0000_5000, 32'h0BAD_F00D); wait_tx();
    exp_st = 8'h00; exp_rd = 32'h0; exp_err = 4'b0100;
    exp_cyc = last_hs_cyc + 1 + int'(TO);
    exp_pending = 1'b1;
    repeat (TO + 5) tick();
    chk("timeout_rsp_consumed", exp_pending, 1'b0);

    // Reset in the middle of TX.
    stall_mode = 1'b1;
    do_req(1'b1, 32'h0000_6000, 32'h5555_AAAA);
    repeat (3) tick();
    rst_n = 1'b0;
    exp_tx.delete();
    tick();
    chk("midrst_tx_valid", tx_valid, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_req_ready_after_release", req_ready, 1'b1);
    chk("midrst_tx_valid_after_release", tx_valid, 1'b0);
    stall_mode = 1'b0;
    repeat (20) tick();
    do_req(1'b0, 32'h0000_7000, 32'h0); wait_tx();
    send_rsp(make_rsp(1'b0, 8'h00, 8'h10, 32'h7654_3210, 8'h00), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
